// File: rtl/mos6502_int_seq.sv
// Interrupt/reset entry sequencer for the mos6502 core: arbitrates RES/NMI/BRK/IRQ
// at instruction boundaries and drives the push / vector-fetch / PC-load bus sequence.
module mos6502_int_seq #(
  parameter logic [7:0]  STACK_PAGE = 8'h01,
  parameter logic [15:0] VEC_NMI    = 16'hFFFA,
  parameter logic [15:0] VEC_RES    = 16'hFFFC,
  parameter logic [15:0] VEC_IRQ    = 16'hFFFE
) (
  input  logic        clk,
  input  logic        res,
  input  logic        rdy,
  input  logic        IRQ,
  input  logic        NMI,
  input  logic        i_flag,
  input  logic        instr_done,
  input  logic        brk_exec,
  input  logic [15:0] pc,
  input  logic [7:0]  p_in,
  input  logic [7:0]  s_in,
  input  logic [7:0]  d_in,
  output logic        busy,
  output logic [1:0]  src,
  output logic [15:0] add_bus,
  output logic [7:0]  d_out,
  output logic        write_en,
  output logic        s_dec,
  output logic        pc_load,
  output logic [15:0] pc_new,
  output logic        set_i,
  output logic [2:0]  state_dbg
);

  // Handshake: there is no valid/ready pair here; rdy is a global hold. An edge with
  // rdy=0 leaves state and every output untouched, only the NMI edge detector runs.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PUSH_H = 3'd1,
    S_PUSH_L = 3'd2,
    S_PUSH_P = 3'd3,
    S_VEC_L  = 3'd4,
    S_VEC_H  = 3'd5,
    S_LOAD   = 3'd6
  } state_t;

  localparam logic [1:0] SRC_RES = 2'b00;
  localparam logic [1:0] SRC_NMI = 2'b01;
  localparam logic [1:0] SRC_IRQ = 2'b10;
  localparam logic [1:0] SRC_BRK = 2'b11;

  state_t      state, state_nxt;
  logic        res_start, start_nxt;
  logic [1:0]  src_nxt;
  logic [7:0]  s_cap, s_cap_nxt;
  logic [15:0] pc_cap, pc_cap_nxt;
  logic [7:0]  vec_lo, vec_lo_nxt;
  logic        nmi_q, nmi_pending, nmi_clr;

  logic        busy_nxt, we_nxt, sdec_nxt, pcl_nxt, seti_nxt;
  logic [15:0] add_nxt, pcn_nxt;
  logic [7:0]  dout_nxt;
  logic [7:0]  sp_m1, sp_m2;

  assign state_dbg = state;

  function automatic logic [15:0] vec_of(input logic [1:0] s);
    case (s)
      SRC_RES: return VEC_RES;
      SRC_NMI: return VEC_NMI;
      default: return VEC_IRQ;
    endcase
  endfunction

  // res_start marks the reset hold: the first rdy edge after release presents PUSH_H.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state       <= S_PUSH_H;
      res_start   <= 1'b1;
      src         <= SRC_RES;
      s_cap       <= 8'h00;
      pc_cap      <= 16'h0000;
      vec_lo      <= 8'h00;
      nmi_q       <= 1'b1;
      nmi_pending <= 1'b0;
      busy        <= 1'b1;
      add_bus     <= 16'h0000;
      d_out       <= 8'h00;
      write_en    <= 1'b1;
      s_dec       <= 1'b0;
      pc_load     <= 1'b0;
      pc_new      <= 16'h0000;
      set_i       <= 1'b0;
    end else begin
      state       <= state_nxt;
      res_start   <= start_nxt;
      src         <= src_nxt;
      s_cap       <= s_cap_nxt;
      pc_cap      <= pc_cap_nxt;
      vec_lo      <= vec_lo_nxt;
      nmi_q       <= NMI;
      // A fresh falling edge wins over a clear in the same cycle.
      nmi_pending <= (nmi_q & ~NMI) | (nmi_pending & ~nmi_clr);
      busy        <= busy_nxt;
      add_bus     <= add_nxt;
      d_out       <= dout_nxt;
      write_en    <= we_nxt;
      s_dec       <= sdec_nxt;
      pc_load     <= pcl_nxt;
      pc_new      <= pcn_nxt;
      set_i       <= seti_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    start_nxt  = res_start;
    src_nxt    = src;
    s_cap_nxt  = s_cap;
    pc_cap_nxt = pc_cap;
    vec_lo_nxt = vec_lo;
    nmi_clr    = 1'b0;
    if (rdy) begin
      if (res_start) begin
        start_nxt  = 1'b0;
        s_cap_nxt  = s_in;
        pc_cap_nxt = pc;
        state_nxt  = S_PUSH_H;
      end else begin
        case (state)
          S_IDLE: begin
            if (instr_done) begin
              if (nmi_pending) begin
                src_nxt   = SRC_NMI;
                state_nxt = S_PUSH_H;
              end else if (brk_exec) begin
                src_nxt   = SRC_BRK;
                state_nxt = S_PUSH_H;
              end else if (!IRQ && !i_flag) begin
                src_nxt   = SRC_IRQ;
                state_nxt = S_PUSH_H;
              end
              s_cap_nxt  = s_in;
              pc_cap_nxt = pc;
            end
          end
          S_PUSH_H: state_nxt = S_PUSH_L;
          S_PUSH_L: state_nxt = S_PUSH_P;
          S_PUSH_P: begin
            state_nxt = S_VEC_L;
            // An NMI pending during an IRQ/BRK entry takes over the vector fetch.
            if (nmi_pending && src[1]) src_nxt = SRC_NMI;
            nmi_clr = (src_nxt == SRC_NMI);
          end
          S_VEC_L: begin
            state_nxt  = S_VEC_H;
            vec_lo_nxt = d_in;
          end
          S_VEC_H: state_nxt = S_LOAD;
          S_LOAD:  state_nxt = S_IDLE;
          default: state_nxt = S_IDLE;
        endcase
      end
    end
  end

  assign sp_m1 = s_cap_nxt - 8'd1;
  assign sp_m2 = s_cap_nxt - 8'd2;

  always_comb begin
    busy_nxt = busy;
    add_nxt  = add_bus;
    dout_nxt = d_out;
    we_nxt   = write_en;
    sdec_nxt = s_dec;
    pcl_nxt  = pc_load;
    pcn_nxt  = pc_new;
    seti_nxt = set_i;
    if (rdy) begin
      busy_nxt = (state_nxt != S_IDLE);
      dout_nxt = 8'h00;
      we_nxt   = 1'b1;
      sdec_nxt = 1'b0;
      pcl_nxt  = 1'b0;
      seti_nxt = 1'b0;
      case (state_nxt)
        S_PUSH_H: begin
          add_nxt  = {STACK_PAGE, s_cap_nxt};
          dout_nxt = (src_nxt == SRC_RES) ? 8'h00 : pc_cap_nxt[15:8];
          we_nxt   = (src_nxt == SRC_RES);
          sdec_nxt = 1'b1;
        end
        S_PUSH_L: begin
          add_nxt  = {STACK_PAGE, sp_m1};
          dout_nxt = (src_nxt == SRC_RES) ? 8'h00 : pc_cap_nxt[7:0];
          we_nxt   = (src_nxt == SRC_RES);
          sdec_nxt = 1'b1;
        end
        S_PUSH_P: begin
          add_nxt  = {STACK_PAGE, sp_m2};
          dout_nxt = (src_nxt == SRC_RES) ? 8'h00 :
                     {p_in[7:6], 1'b1, (src_nxt == SRC_BRK), p_in[3:0]};
          we_nxt   = (src_nxt == SRC_RES);
          sdec_nxt = 1'b1;
        end
        S_VEC_L: add_nxt = vec_of(src_nxt);
        S_VEC_H: add_nxt = add_bus + 16'd1;
        S_LOAD: begin
          pcn_nxt  = {d_in, vec_lo};
          pcl_nxt  = 1'b1;
          seti_nxt = 1'b1;
        end
        default: add_nxt = add_bus;
      endcase
    end
  end

endmodule
